// File: rtl/mfp_clock_divider_gen_if.sv
// mfp_clock_divider_gen_if: mode request in, divided clocks,
// rise strobes and lock status out.
interface mfp_clock_divider_gen_if #(
  parameter int CHANNELS = 4
);
  logic [1:0]          mode;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] clk_rise;
  logic [1:0]          mode_active;
  logic                locked;

  modport master (
    input  mode,
    output clk_out,
    output clk_rise,
    output mode_active,
    output locked
  );

  modport slave (
    output mode,
    input  clk_out,
    input  clk_rise,
    input  mode_active,
    input  locked
  );
endinterface

// File: rtl/mfp_clock_divider_gen.sv
// mfp_clock_divider_gen: multi-channel divided clocks with
// glitch-free runtime ratio changes (drain, reload, settle).
module mfp_clock_divider_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 8,
  parameter logic [CHANNELS*CNT_W-1:0] DIV_BASE =
    {8'd4, 8'd2, 8'd3, 8'd1},
  parameter int LOCK_CYCLES = 16
) (
  input  logic gclk,
  input  logic rst_n,
  mfp_clock_divider_gen_if.master bus
);

  localparam int HW = CNT_W + 2;
  localparam int SW =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    RUN,
    STOP
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [1:0]          mode_meta;
  logic [1:0]          mode_sync;
  logic [1:0]          mode_active;
  logic [SW-1:0]       settle_cnt;
  logic                locked;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] clk_rise;
  logic                mismatch;
  logic                settle_done;
  logic                hold;

  // Half-period minus one; a zero base field acts as 1.
  function automatic logic [HW-1:0] half_m1(
    input logic [CNT_W-1:0] base,
    input logic [1:0]       m
  );
    logic [HW-1:0] h;
    h = (base == '0) ? HW'(1) : HW'(base);
    case (m)
      2'd1:    h = h << 1;
      2'd2:    h = h << 2;
      default: h = h;
    endcase
    return h - HW'(1);
  endfunction

  assign mismatch    = mode_sync != mode_active;
  assign settle_done = settle_cnt == SW'(LOCK_CYCLES - 1);
  assign hold        = mode_active == 2'd3;

  // Mode synchroniser and state register
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta <= 2'd0;
      mode_sync <= 2'd0;
      state     <= LOAD;
    end else begin
      mode_meta <= bus.mode;
      mode_sync <= mode_meta;
      state     <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:   state_nx = SETTLE;
      SETTLE: begin
        if (mismatch)         state_nx = STOP;
        else if (settle_done) state_nx = RUN;
      end
      RUN:    if (mismatch) state_nx = STOP;
      STOP:   if (clk_out == '0) state_nx = LOAD;
    endcase
  end

  // Applied mode, settle count and lock flag
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_active <= 2'd0;
      settle_cnt  <= '0;
      locked      <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          mode_active <= mode_sync;
          settle_cnt  <= '0;
          locked      <= 1'b0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + SW'(1);
          if (!mismatch && settle_done) locked <= 1'b1;
        end
        RUN:  if (mismatch) locked <= 1'b0;
        STOP: locked <= 1'b0;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [HW-1:0] cnt;
    logic [HW-1:0] h_load;
    logic [HW-1:0] h_act;
    logic          co;
    logic          cr;

    assign h_load = half_m1(DIV_BASE[c*CNT_W +: CNT_W], mode_sync);
    assign h_act  = half_m1(DIV_BASE[c*CNT_W +: CNT_W], mode_active);

    // Half-period counter; STOP only lets a high phase finish
    always_ff @(posedge gclk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        co  <= 1'b0;
        cr  <= 1'b0;
      end else begin
        cr <= 1'b0;
        unique case (state)
          LOAD: begin
            cnt <= h_load;
            co  <= 1'b0;
          end
          SETTLE, RUN: begin
            if (cnt == '0) begin
              cnt <= h_act;
              if (!hold) begin
                co <= ~co;
                cr <= ~co;
              end
            end else begin
              cnt <= cnt - HW'(1);
            end
          end
          STOP: begin
            if (co) begin
              if (cnt == '0) begin
                co  <= 1'b0;
                cnt <= h_act;
              end else begin
                cnt <= cnt - HW'(1);
              end
            end
          end
        endcase
      end
    end

    assign clk_out[c]  = co;
    assign clk_rise[c] = cr;
  end

  assign bus.clk_out     = clk_out;
  assign bus.clk_rise    = clk_rise;
  assign bus.mode_active = mode_active;
  assign bus.locked      = locked;

endmodule

// File: tb/tb_mfp_clock_divider_gen.sv
// tb_mfp_clock_divider_gen: directed vectors for ratios,
// relock timing, HOLD, STOP absorption, async reset, zero base.
module tb_mfp_clock_divider_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mfp_clock_divider_gen_if #(.CHANNELS(4)) bus ();
  mfp_clock_divider_gen_if #(.CHANNELS(2)) zbus ();

  mfp_clock_divider_gen #(
    .CHANNELS(4),
    .CNT_W(8),
    .DIV_BASE(32'h04020301),
    .LOCK_CYCLES(16)
  ) dut (
    .gclk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  mfp_clock_divider_gen #(
    .CHANNELS(2),
    .CNT_W(8),
    .DIV_BASE(16'h0200),
    .LOCK_CYCLES(1)
  ) u_z (
    .gclk(clk),
    .rst_n(rst_n),
    .bus(zbus)
  );

  typedef struct {
    int mode;
    int ch;
    int period;
  } vec_t;

  vec_t tbl[12];
  int   checks = 0;
  int   failures = 0;
  int   cur_mode = 0;
  int   bases[4] = '{1, 3, 2, 4};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int hlen(input int c, input int m);
    if (m == 3) return 0;
    return bases[c] << m;
  endfunction

  // High-phase length and rise-strobe monitor for the main DUT
  logic [3:0] prev;
  int hl[4];
  int he[4];
  always @(negedge clk) begin
    if (!rst_n) begin
      prev = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (bus.clk_out[c] && !prev[c]) begin
          chk("rise_strobe", int'(bus.clk_rise[c]), 1);
          hl[c] = 1;
          he[c] = hlen(c, cur_mode);
        end else begin
          chk("no_strobe", int'(bus.clk_rise[c]), 0);
          if (bus.clk_out[c]) hl[c]++;
          else if (prev[c]) chk("high_len", hl[c], he[c]);
        end
      end
      prev = bus.clk_out;
    end
  end

  task automatic change_mode(input int m);
    int n;
    bus.mode = 2'(m);
    n = 0;
    while (bus.locked === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lock_drop", n, 3);
    n = 0;
    while (bus.mode_active !== 2'(m) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mode_active", int'(bus.mode_active), m);
    cur_mode = m;
    n = 0;
    while (bus.locked !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("relock_cycles", n, 16);
  endtask

  task automatic measure(input int c, output int per);
    int n;
    n = 0;
    while (bus.clk_rise[c] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      per = -1;
    end else begin
      per = 0;
      do begin
        @(negedge clk);
        per++;
      end while (bus.clk_rise[c] !== 1'b1 && per < 200);
    end
  endtask

  int n, nz, per, rises, bad, edges, dbl;
  logic lprev, zprev, zrprev;

  initial begin
    tbl[0]  = '{0, 0, 2};
    tbl[1]  = '{0, 1, 6};
    tbl[2]  = '{0, 2, 4};
    tbl[3]  = '{0, 3, 8};
    tbl[4]  = '{1, 0, 4};
    tbl[5]  = '{1, 1, 12};
    tbl[6]  = '{1, 2, 8};
    tbl[7]  = '{1, 3, 16};
    tbl[8]  = '{2, 0, 8};
    tbl[9]  = '{2, 1, 24};
    tbl[10] = '{2, 2, 16};
    tbl[11] = '{2, 3, 32};

    bus.mode  = 2'd0;
    zbus.mode = 2'd0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_out", int'(bus.clk_out), 0);
    chk("rst_clk_rise", int'(bus.clk_rise), 0);
    chk("rst_mode_active", int'(bus.mode_active), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_z_clk_out", int'(zbus.clk_out), 0);

    rst_n = 1'b1;
    n = 0;
    nz = -1;
    while (bus.locked !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (nz < 0 && zbus.locked === 1'b1) nz = n;
    end
    chk("first_lock", n, 17);
    chk("z_first_lock", nz, 2);
    chk("first_mode", int'(bus.mode_active), 0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].mode != int'(bus.mode)) change_mode(tbl[i].mode);
      measure(tbl[i].ch, per);
      chk($sformatf("period_m%0d_ch%0d", tbl[i].mode, tbl[i].ch),
          per, tbl[i].period);
    end

    // Request mode 1 mid-drain, then 2 while still in STOP
    n = 0;
    while (bus.clk_rise[3] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stop_rise_seen", int'(n < 100), 1);
    bus.mode = 2'd1;
    n = 0;
    while (bus.locked === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stop_lock_drop", n, 3);
    bus.mode = 2'd2;
    rises = 0;
    bad = 0;
    lprev = bus.locked;
    repeat (200) begin
      @(negedge clk);
      if (bus.locked && !lprev) rises++;
      lprev = bus.locked;
      if (bus.mode_active != 2'd2) bad++;
    end
    chk("stop_single_relock", rises, 1);
    chk("stop_mode_stays", bad, 0);
    chk("stop_locked", int'(bus.locked), 1);
    measure(1, per);
    chk("stop_period_ch1", per, 24);

    // HOLD mode
    change_mode(3);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.clk_out != 4'd0 || bus.clk_rise != 4'd0) bad++;
    end
    chk("hold_quiet", bad, 0);
    chk("hold_locked", int'(bus.locked), 1);
    chk("hold_mode_active", int'(bus.mode_active), 3);

    // Async reset in the middle of a high phase
    change_mode(1);
    n = 0;
    while (bus.clk_rise[3] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_high", int'(bus.clk_out[3]), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cur_mode = 0;
    #1;
    chk("arst_clk_out", int'(bus.clk_out), 0);
    chk("arst_clk_rise", int'(bus.clk_rise), 0);
    chk("arst_locked", int'(bus.locked), 0);
    chk("arst_mode_active", int'(bus.mode_active), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    bad = 0;
    while (bus.mode_active !== 2'd1 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.locked) bad++;
    end
    cur_mode = 1;
    chk("arst_no_early_lock", bad, 0);
    chk("arst_mode1", int'(bus.mode_active), 1);
    n = 0;
    while (bus.locked !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("arst_relock", n, 16);
    measure(1, per);
    chk("arst_period_ch1", per, 12);

    // Zero base field: toggles every cycle
    n = 0;
    while (zbus.locked !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("z_locked", int'(zbus.locked), 1);
    rises = 0;
    edges = 0;
    dbl = 0;
    zprev = zbus.clk_out[0];
    zrprev = zbus.clk_rise[0];
    repeat (40) begin
      @(negedge clk);
      if (zbus.clk_rise[0]) rises++;
      if (zbus.clk_out[0] && !zprev) edges++;
      if (zbus.clk_rise[0] && zrprev) dbl++;
      zprev = zbus.clk_out[0];
      zrprev = zbus.clk_rise[0];
    end
    chk("z_rise_count", rises, 20);
    chk("z_edge_count", edges, 20);
    chk("z_strobe_width", dbl, 0);
    n = 0;
    while (zbus.clk_rise[1] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    per = 0;
    do begin
      @(negedge clk);
      per++;
    end while (zbus.clk_rise[1] !== 1'b1 && per < 50);
    chk("z_period_ch1", per, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
